ram_port_arbiter: RTL

// - Shares the FPGA-side on-chip RAM slave port (ram_* on soc_system) between two requesters.
//   - Requester 0: zone-colour statistics writer.
//   - Requester 1: LED-strip frame reader.
// - Round-robin arbitration. Drives the RAM port from registers.
// - Tracks outstanding reads and returns each read response to the requester that issued it.
// - Sits on clk_100m beside soc_system in the top level.

---
 rtl/ambilight_pkg.sv | 11 +
 rtl/rr_arb2.sv | 17 +
 rtl/ram_port_arbiter.sv | 96 +++++++++
 3 files changed

// File: rtl/ambilight_pkg.sv
// ambilight_pkg: shared RAM geometry, requester IDs and the read-tag record
package ambilight_pkg;
  localparam int RAM_AW = 13;
  localparam int RAM_DW = 32;
  localparam logic REQ_ZONE = 1'b0;
  localparam logic REQ_LED = 1'b1;
  typedef struct packed {
    logic valid;
    logic owner;
  } rd_tag_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant; the pointer names who wins a tie
module rr_arb2
  import ambilight_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic ptr;
  always_comb gnt = !reset_n ? 2'b00 : (req == 2'b11) ? (ptr == REQ_LED ? 2'b10 : 2'b01) : req;
  // after a grant the other requester gets priority, so nobody waits more than one grant
  always_ff @(posedge clk) begin
    if (!reset_n) ptr <= REQ_ZONE;
    else if (|gnt) ptr <= gnt[0] ? REQ_LED : REQ_ZONE;
  end
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares the on-chip RAM slave port between the zone writer and LED reader,
// issuing from registers and routing each read response back to its issuer
module ram_port_arbiter
  import ambilight_pkg::*;
#(
  parameter int AW         = RAM_AW,
  parameter int DW         = RAM_DW,
  parameter int BEW        = DW / 8,
  parameter int RD_LATENCY = 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           r0_valid,
  output logic           r0_ready,
  input  logic           r0_write,
  input  logic [AW-1:0]  r0_addr,
  input  logic [DW-1:0]  r0_wdata,
  input  logic [BEW-1:0] r0_be,
  output logic           r0_rvalid,
  output logic [DW-1:0]  r0_rdata,
  input  logic           r1_valid,
  output logic           r1_ready,
  input  logic           r1_write,
  input  logic [AW-1:0]  r1_addr,
  input  logic [DW-1:0]  r1_wdata,
  input  logic [BEW-1:0] r1_be,
  output logic           r1_rvalid,
  output logic [DW-1:0]  r1_rdata,
  output logic [AW-1:0]  ram_address,
  output logic           ram_chipselect,
  output logic           ram_clken,
  output logic           ram_write,
  output logic [DW-1:0]  ram_writedata,
  output logic [BEW-1:0] ram_byteenable,
  input  logic [DW-1:0]  ram_readdata
);
  generate
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
      $error("ram_port_arbiter: RD_LATENCY must be within 1..4");
    end
  endgenerate
  logic [1:0] gnt;
  logic sel, sel_write, granted;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [BEW-1:0] sel_be;
  rd_tag_t [RD_LATENCY:0] tags;
  rd_tag_t resp;
  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     ({r1_valid, r0_valid}),
    .gnt     (gnt)
  );
  always_comb begin
    r0_ready  = gnt[0];
    r1_ready  = gnt[1];
    granted   = |gnt;
    sel       = gnt[1] ? REQ_LED : REQ_ZONE;
    sel_write = sel == REQ_LED ? r1_write : r0_write;
    sel_addr  = sel == REQ_LED ? r1_addr : r0_addr;
    sel_wdata = sel == REQ_LED ? r1_wdata : r0_wdata;
    sel_be    = sel == REQ_LED ? r1_be : r0_be;
    resp      = tags[RD_LATENCY];
  end
  // tag stage k lines up with the RAM cycle k clocks after issue, so the last stage meets ram_readdata
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ram_address    <= '0;
      ram_chipselect <= 1'b0;
      ram_clken      <= 1'b0;
      ram_write      <= 1'b0;
      ram_writedata  <= '0;
      ram_byteenable <= '0;
      tags           <= '0;
      r0_rvalid      <= 1'b0;
      r1_rvalid      <= 1'b0;
      r0_rdata       <= '0;
      r1_rdata       <= '0;
    end else begin
      ram_clken      <= 1'b1;
      ram_chipselect <= granted;
      ram_write      <= granted & sel_write;
      if (granted) begin
        ram_address    <= sel_addr;
        ram_writedata  <= sel_wdata;
        ram_byteenable <= sel_write ? sel_be : '1;
      end
      tags      <= {tags[RD_LATENCY-1:0], rd_tag_t'{valid: granted & ~sel_write, owner: sel}};
      r0_rvalid <= resp.valid && resp.owner == REQ_ZONE;
      r1_rvalid <= resp.valid && resp.owner == REQ_LED;
      if (resp.valid && resp.owner == REQ_ZONE) r0_rdata <= ram_readdata;
      if (resp.valid && resp.owner == REQ_LED) r1_rdata <= ram_readdata;
    end
  end
endmodule
